// File: rtl/psum_acc_pkg.sv
// Shared types and helpers for the psum accumulator and its drain serializer.
package psum_acc_pkg;

  // Widest accumulator the helper functions support.
  localparam int unsigned SAT_MAX_W = 32;

  typedef enum logic [0:0] {
    StIdle,
    StDrain
  } drain_state_t;

  // Unsigned add clipped to 2^width-1; result is {overflow, sum}.
  function automatic logic [SAT_MAX_W:0] sat_add(input logic [SAT_MAX_W-1:0] a,
                                                 input logic [SAT_MAX_W-1:0] b,
                                                 input int unsigned          width);
    logic [SAT_MAX_W:0] sum;
    logic [SAT_MAX_W:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = '1;
    lim = ~(lim << width);
    if (sum > lim) begin
      return {1'b1, lim[SAT_MAX_W-1:0]};
    end
    return {1'b0, sum[SAT_MAX_W-1:0]};
  endfunction

  // Zero passes means one beat; anything above the maximum is pinned to it.
  function automatic int unsigned clamp_passes(input int unsigned passes,
                                               input int unsigned max_passes);
    if (passes == 0) begin
      return 1;
    end
    if (passes > max_passes) begin
      return max_passes;
    end
    return passes;
  endfunction

endpackage

// File: rtl/psum_drain_serializer.sv
// Holds one finished vector and streams it out a column at a time.
module psum_drain_serializer
  import psum_acc_pkg::*;
#(
  parameter int unsigned NUM_COLS  = 3,
  parameter int unsigned ACC_WIDTH = 12,
  parameter int unsigned COL_W     = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic [ACC_WIDTH-1:0] load_data_i [NUM_COLS],
  output logic                 busy_o,
  output logic                 vacating_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [ACC_WIDTH-1:0] out_data_o,
  output logic [COL_W-1:0]     out_col_o,
  output logic                 out_last_o
);

  localparam logic [COL_W-1:0] LastCol = COL_W'(NUM_COLS - 1);

  drain_state_t         state_q, state_d;
  logic [COL_W-1:0]     col_q, col_d;
  logic [ACC_WIDTH-1:0] bank_q [NUM_COLS];
  logic [ACC_WIDTH-1:0] bank_d [NUM_COLS];
  logic                 draining;
  logic                 handshake;

  // Output decode and next-state for FSM, column counter and bank.
  always_comb begin
    draining    = (state_q == StDrain);
    out_valid_o = draining;
    out_last_o  = draining && (col_q == LastCol);
    out_col_o   = col_q;
    out_data_o  = draining ? bank_q[col_q] : '0;
    handshake   = draining && out_ready_i;
    busy_o      = draining;
    vacating_o  = handshake && out_last_o;

    state_d = state_q;
    col_d   = col_q;
    bank_d  = bank_q;

    if (handshake) begin
      if (out_last_o) begin
        state_d = StIdle;
        col_d   = '0;
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
    // Upstream only loads when the bank is empty or being vacated this cycle.
    if (load_i) begin
      bank_d  = load_data_i;
      state_d = StDrain;
      col_d   = '0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      col_q   <= '0;
      for (int c = 0; c < int'(NUM_COLS); c++) begin
        bank_q[c] <= '0;
      end
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      bank_q  <= bank_d;
    end
  end

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates cfg_passes psum beats per column with saturation, then hands the
// finished vector to the drain serializer.
module psum_accumulator
  import psum_acc_pkg::*;
#(
  parameter int unsigned PE_WIDTH   = 4,
  parameter int unsigned NUM_COLS   = 3,
  parameter int unsigned ACC_WIDTH  = 12,
  parameter int unsigned MAX_PASSES = 16,
  localparam int unsigned PASS_W    = $clog2(MAX_PASSES + 1),
  localparam int unsigned COL_W     = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PASS_W-1:0]    cfg_passes,
  input  logic                 psum_valid,
  output logic                 psum_ready,
  input  logic [PE_WIDTH-1:0]  psum_in [NUM_COLS],
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic [COL_W-1:0]     out_col,
  output logic                 out_last,
  output logic                 sat_flag
);

  logic [ACC_WIDTH-1:0] acc_q [NUM_COLS];
  logic [ACC_WIDTH-1:0] acc_d [NUM_COLS];
  logic [ACC_WIDTH-1:0] sum   [NUM_COLS];
  logic [SAT_MAX_W:0]   add_res [NUM_COLS];
  logic [PASS_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [PASS_W-1:0]    passes_lat_q, passes_lat_d;
  logic                 sat_q, sat_d;

  logic [PASS_W-1:0]    passes_first;
  logic [PASS_W-1:0]    passes_eff;
  logic                 first_beat;
  logic                 last_beat;
  logic                 accept;
  logic                 any_ovf;
  logic                 drain_busy;
  logic                 drain_vacating;
  logic                 load;

  // Beat classification, backpressure, per-lane sums and next state.
  always_comb begin
    passes_first = PASS_W'(clamp_passes(32'(cfg_passes), MAX_PASSES));
    first_beat   = (beat_cnt_q == '0);
    passes_eff   = first_beat ? passes_first : passes_lat_q;
    last_beat    = (beat_cnt_q == passes_eff - PASS_W'(1));
    // Only a last beat needs the drain bank, so only it can be stalled.
    psum_ready   = rst && !(last_beat && drain_busy && !drain_vacating);
    accept       = psum_valid && psum_ready;
    load         = accept && last_beat;

    any_ovf = 1'b0;
    for (int c = 0; c < int'(NUM_COLS); c++) begin
      add_res[c] = sat_add(SAT_MAX_W'(acc_q[c]), SAT_MAX_W'(psum_in[c]), ACC_WIDTH);
      sum[c]     = first_beat ? ACC_WIDTH'(psum_in[c]) : add_res[c][ACC_WIDTH-1:0];
      any_ovf    = any_ovf | (!first_beat && add_res[c][SAT_MAX_W]);
    end

    acc_d        = acc_q;
    beat_cnt_d   = beat_cnt_q;
    passes_lat_d = passes_lat_q;
    sat_d        = sat_q;
    if (accept) begin
      acc_d      = sum;
      beat_cnt_d = last_beat ? '0 : beat_cnt_q + PASS_W'(1);
      if (first_beat) begin
        passes_lat_d = passes_first;
      end
      if (any_ovf) begin
        sat_d = 1'b1;
      end
    end
  end

  // Accumulator state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      beat_cnt_q   <= '0;
      passes_lat_q <= '0;
      sat_q        <= 1'b0;
      for (int c = 0; c < int'(NUM_COLS); c++) begin
        acc_q[c] <= '0;
      end
    end else begin
      acc_q        <= acc_d;
      beat_cnt_q   <= beat_cnt_d;
      passes_lat_q <= passes_lat_d;
      sat_q        <= sat_d;
    end
  end

  assign sat_flag = sat_q;

  psum_drain_serializer #(
    .NUM_COLS (NUM_COLS),
    .ACC_WIDTH(ACC_WIDTH),
    .COL_W    (COL_W)
  ) u_drain (
    .clk_i      (clk),
    .rst_ni     (rst),
    .load_i     (load),
    .load_data_i(sum),
    .busy_o     (drain_busy),
    .vacating_o (drain_vacating),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .out_col_o  (out_col),
    .out_last_o (out_last)
  );

endmodule

// File: tb/tb_psum_accumulator.sv
// Two accumulators (12-bit and 6-bit words) share one stimulus stream and are
// compared against a queue-based model of the expected output words.
module tb_psum_accumulator;

  localparam int unsigned MAXP = 16;

  logic       clk;
  logic       rst;
  logic [4:0] cfg_passes;
  logic       psum_valid;
  logic [3:0] psum_in [3];
  logic       out_ready;

  logic        psum_ready, out_valid, out_last, sat_flag;
  logic [11:0] out_data;
  logic [1:0]  out_col;
  logic        psum_ready6, out_valid6, out_last6, sat_flag6;
  logic [5:0]  out_data6;
  logic [1:0]  out_col6;

  psum_accumulator #(
    .PE_WIDTH  (4),
    .NUM_COLS  (3),
    .ACC_WIDTH (12),
    .MAX_PASSES(MAXP)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_passes(cfg_passes),
    .psum_valid(psum_valid),
    .psum_ready(psum_ready),
    .psum_in   (psum_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_col   (out_col),
    .out_last  (out_last),
    .sat_flag  (sat_flag)
  );

  psum_accumulator #(
    .PE_WIDTH  (4),
    .NUM_COLS  (3),
    .ACC_WIDTH (6),
    .MAX_PASSES(MAXP)
  ) u_dut6 (
    .clk       (clk),
    .rst       (rst),
    .cfg_passes(cfg_passes),
    .psum_valid(psum_valid),
    .psum_ready(psum_ready6),
    .psum_in   (psum_in),
    .out_valid (out_valid6),
    .out_ready (out_ready),
    .out_data  (out_data6),
    .out_col   (out_col6),
    .out_last  (out_last6),
    .sat_flag  (sat_flag6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned data;
    int unsigned col;
    bit          last;
  } word_t;

  word_t       q12[$];
  word_t       q6[$];
  int unsigned tot [3];
  int unsigned cnt_m;
  int unsigned passes_m;
  bit          sat12_m;
  bit          sat6_m;
  bit          acc_flag;
  int          checks;
  int          errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int unsigned clampm(input int unsigned p);
    if (p == 0) return 1;
    if (p > MAXP) return MAXP;
    return p;
  endfunction

  function automatic int unsigned minu(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

  // Check outputs at the negedge, advance the model across the next posedge.
  task automatic step();
    bit          exp_valid;
    bit          exp_ready;
    bit          head_last;
    int unsigned eff;
    @(negedge clk);
    exp_valid = (q12.size() != 0);
    head_last = exp_valid && q12[0].last;
    chk("out_valid", out_valid, exp_valid);
    chk("out_valid6", out_valid6, exp_valid);
    if (exp_valid) begin
      chk("out_data", out_data, q12[0].data);
      chk("out_col", out_col, q12[0].col);
      chk("out_last", out_last, q12[0].last);
      chk("out_data6", out_data6, q6[0].data);
      chk("out_col6", out_col6, q6[0].col);
    end
    eff       = (cnt_m == 0) ? clampm(cfg_passes) : passes_m;
    exp_ready = rst && !((cnt_m == eff - 1) && exp_valid && !(out_ready && head_last));
    chk("psum_ready", psum_ready, exp_ready);
    chk("psum_ready6", psum_ready6, exp_ready);
    chk("sat_flag", sat_flag, sat12_m);
    chk("sat_flag6", sat_flag6, sat6_m);

    acc_flag = 1'b0;
    if (!rst) begin
      q12.delete();
      q6.delete();
      cnt_m   = 0;
      sat12_m = 1'b0;
      sat6_m  = 1'b0;
    end else begin
      if (exp_valid && out_ready) begin
        void'(q12.pop_front());
        void'(q6.pop_front());
      end
      if (psum_valid && exp_ready) begin
        acc_flag = 1'b1;
        if (cnt_m == 0) begin
          passes_m = eff;
          for (int c = 0; c < 3; c++) tot[c] = 0;
        end
        for (int c = 0; c < 3; c++) begin
          tot[c] += psum_in[c];
          if (tot[c] > 63) sat6_m = 1'b1;
          if (tot[c] > 4095) sat12_m = 1'b1;
        end
        cnt_m++;
        if (cnt_m == passes_m) begin
          cnt_m = 0;
          for (int c = 0; c < 3; c++) begin
            q12.push_back('{data: minu(tot[c], 4095), col: c, last: (c == 2)});
            q6.push_back('{data: minu(tot[c], 63), col: c, last: (c == 2)});
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Present one beat and hold it until accepted, within a cycle budget.
  task automatic send(input int unsigned cfg, input int unsigned a, input int unsigned b,
                      input int unsigned c);
    cfg_passes = 5'(cfg);
    psum_in[0] = 4'(a);
    psum_in[1] = 4'(b);
    psum_in[2] = 4'(c);
    psum_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      step();
      if (acc_flag) break;
    end
    chk("send_accepted", acc_flag, 1'b1);
    psum_valid = 1'b0;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    cnt_m      = 0;
    passes_m   = 1;
    sat12_m    = 1'b0;
    sat6_m     = 1'b0;
    acc_flag   = 1'b0;
    rst        = 1'b0;
    cfg_passes = '0;
    psum_valid = 1'b0;
    out_ready  = 1'b0;
    for (int c = 0; c < 3; c++) psum_in[c] = '0;

    // Reset state.
    idle(2);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_col", out_col, 0);
    chk("rst_out_last", out_last, 0);
    rst = 1'b1;
    idle(1);

    // Single-beat vector.
    out_ready = 1'b1;
    send(1, 1, 2, 3);
    idle(4);

    // Four-beat accumulation.
    for (int i = 0; i < 4; i++) send(4, 15, 15, 15);
    idle(4);

    // Backpressure on the second vector's last beat, then back-to-back drain.
    out_ready = 1'b0;
    send(1, 1, 1, 1);
    cfg_passes = 5'd1;
    psum_in[0] = 4'd2;
    psum_in[1] = 4'd2;
    psum_in[2] = 4'd2;
    psum_valid = 1'b1;
    idle(4);
    out_ready = 1'b1;
    send(1, 2, 2, 2);
    idle(5);

    // Saturation in the narrow instance; flag stays set afterwards.
    for (int i = 0; i < 8; i++) send(8, 15, 0, 15);
    idle(4);
    send(1, 1, 1, 1);
    idle(4);

    // Reset in the middle of a vector.
    send(4, 7, 7, 7);
    send(4, 7, 7, 7);
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    send(1, 5, 6, 7);
    idle(4);

    // Clamping of cfg_passes.
    send(0, 9, 8, 7);
    idle(4);
    for (int i = 0; i < 16; i++) send(MAXP + 1, 1, 2, 3);
    idle(4);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      psum_valid = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      cfg_passes = 5'($urandom_range(0, 19));
      for (int c = 0; c < 3; c++) psum_in[c] = 4'($urandom_range(0, 15));
      step();
    end
    psum_valid = 1'b0;
    out_ready  = 1'b1;
    idle(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
